// File: rtl/video_pkg.sv
// Shared constants for the 80x60 tile fetch window and the VRAM arbiter state encoding.
`timescale 1ns/1ps
package video_pkg;

  localparam int FETCH_H_MIN   = -8;
  localparam int FETCH_H_MAX   = 631;
  localparam int FETCH_V_LINES = 480;
  localparam int TILES_PER_ROW = 80;
  localparam int TILE_SHIFT    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vram_tile_addr.sv
// Combinational tile-map address for the current beam position:
// vbase + (vcntr >> 3) * 80 + ((hcntr + 8) >> 3), modulo 2^AW.
`timescale 1ns/1ps
module vram_tile_addr
  import video_pkg::*;
#(
  parameter int HSIZE = 10,
  parameter int VSIZE = 10,
  parameter int AW    = 16
) (
  input  logic [HSIZE-1:0] hcntr,
  input  logic [VSIZE-1:0] vcntr,
  input  logic [AW-1:0]    vbase,
  output logic [AW-1:0]    addr
);

  logic [HSIZE-1:0] hshift;
  logic [AW-1:0]    row;
  logic [AW-1:0]    col;

  // Biasing by +8 maps the first slot (hcntr = -8) onto column 0.
  assign hshift = hcntr + HSIZE'(-FETCH_H_MIN);
  assign row    = AW'(vcntr >> TILE_SHIFT);
  assign col    = AW'(hshift >> TILE_SHIFT);
  assign addr   = vbase + row * AW'(TILES_PER_ROW) + col;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video tile fetches pre-empt CPU accesses on slot cycles.
// Optional stall counter output enabled by defining VRAM_ARB_STATS_EN.
`timescale 1ns/1ps
module vram_arbiter
  import video_pkg::*;
#(
  parameter int            HSIZE = 10,
  parameter int            VSIZE = 10,
  parameter int            AW    = 16,
  parameter int            DW    = 8,
  parameter logic [AW-1:0] VBASE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [HSIZE-1:0] hcntr,
  input  logic [VSIZE-1:0] vcntr,
  input  logic             vactive,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic             cpu_ack,
  output logic [DW-1:0]    cpu_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             vid_valid,
`ifdef VRAM_ARB_STATS_EN
  output logic [DW-1:0]    vid_data,
  output logic [15:0]      stall_cnt
`else
  output logic [DW-1:0]    vid_data
`endif
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          h_in_window;
  logic          vid_slot;
  logic          cpu_issue;
  logic [AW-1:0] vid_addr;

  vram_tile_addr #(
    .HSIZE (HSIZE),
    .VSIZE (VSIZE),
    .AW    (AW)
  ) u_tile_addr (
    .hcntr (hcntr),
    .vcntr (vcntr),
    .vbase (VBASE),
    .addr  (vid_addr)
  );

  // The counter wraps -160..-1 onto the top of its range, so the negative
  // part of the window is matched against the wrapped encoding.
  assign h_in_window = (int'(hcntr) <= FETCH_H_MAX) ||
                       (int'(hcntr) >= (1 << HSIZE) + FETCH_H_MIN);
  assign vid_slot    = vactive && (int'(vcntr) < FETCH_V_LINES) && h_in_window &&
                       (hcntr[TILE_SHIFT-1:0] == '0);
  assign cpu_issue   = (state == ST_IDLE) && cpu_req && !vid_slot;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cpu_issue) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    if (vid_slot) begin
      mem_addr = vid_addr;
    end else if (cpu_issue) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
    if (state == ST_RESP) begin
      cpu_ack   = 1'b1;
      cpu_rdata = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vid_valid <= 1'b0;
    else        vid_valid <= vid_slot;
  end

  // The VRAM output register already holds the fetched tile for exactly this cycle.
  assign vid_data = vid_valid ? mem_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
  logic cpu_stall;
  assign cpu_stall = (state == ST_IDLE) && cpu_req && vid_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cnt <= '0;
    else if (cpu_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: window vector table, CPU sequences and a full-line scan.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int          HSIZE = 10;
  localparam int          VSIZE = 10;
  localparam int          AW    = 16;
  localparam int          DW    = 8;
  localparam logic [15:0] VBASE = 16'h4000;

  typedef struct {
    int          h;
    int          v;
    bit          va;
    bit          exp_slot;
    logic [15:0] exp_addr;
  } win_vec_t;

  typedef struct {
    logic [7:0] data;
    bit         is_write;
  } cpu_exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [HSIZE-1:0] hcntr;
  logic [VSIZE-1:0] vcntr;
  logic             vactive;
  logic             cpu_req;
  logic             cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_ack;
  logic [DW-1:0]    cpu_rdata;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             vid_valid;
  logic [DW-1:0]    vid_data;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(
    .HSIZE (HSIZE),
    .VSIZE (VSIZE),
    .AW    (AW),
    .DW    (DW),
    .VBASE (VBASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hcntr     (hcntr),
    .vcntr     (vcntr),
    .vactive   (vactive),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .vid_valid (vid_valid),
`ifdef VRAM_ARB_STATS_EN
    .vid_data  (vid_data),
    .stall_cnt (stall_cnt)
`else
    .vid_data  (vid_data)
`endif
  );

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 13) ^ (i >> 8));
  endfunction

  // Synchronous single-port VRAM, one cycle read latency.
  logic [7:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  logic [7:0] shadow [0:65535];
  logic [7:0] vid_q [$];
  cpu_exp_t   cpu_q [$];

  int n_checks   = 0;
  int n_errors   = 0;
  int n_issued   = 0;
  int n_acked    = 0;
  int vid_pulses = 0;
  bit count_vid  = 1'b0;

  int h_i    = 0;
  int v_i    = 500;
  bit va_i   = 1'b0;
  bit tg_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_slot(int h, int v, bit va);
    return va && (v < 480) && (h >= -8) && (h <= 631) && (h % 8 == 0);
  endfunction

  function automatic logic [15:0] model_addr(int h, int v);
    int a;
    a = int'(VBASE) + (v / 8) * 80 + (h + 8) / 8;
    return 16'(a);
  endfunction

  task automatic apply_timing();
    hcntr   = 10'(h_i);
    vcntr   = 10'(v_i);
    vactive = va_i;
  endtask

  task automatic tick();
    @(negedge clk);
    if (tg_run) begin
      h_i++;
      if (h_i > 639) begin
        h_i = -160;
        v_i = (v_i + 1) % 525;
      end
      va_i = (v_i < 480);
    end
    apply_timing();
  endtask

  // One observation per cycle: retire last cycle's fetch, expect this cycle's, retire CPU acks.
  task automatic sample();
    logic [15:0] a;
    logic [7:0]  e;
    cpu_exp_t    c;
    #1;
    if (vid_q.size() != 0) begin
      e = vid_q.pop_front();
      check("vid_valid", vid_valid, 1);
      check("vid_data", vid_data, e);
    end else begin
      check("vid_valid_idle", vid_valid, 0);
    end
    if (count_vid && vid_valid) vid_pulses++;
    if (model_slot(h_i, v_i, va_i)) begin
      a = model_addr(h_i, v_i);
      check("slot_addr", mem_addr, a);
      check("slot_no_we", mem_we, 0);
      vid_q.push_back(shadow[a]);
    end
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        check("ack_without_request", cpu_ack, 0);
      end else begin
        c = cpu_q.pop_front();
        n_acked++;
        if (!c.is_write) check("cpu_rdata", cpu_rdata, c.data);
      end
    end
  endtask

  // Issues one request in the next cycle and holds it through the ack cycle.
  task automatic cpu_access(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                            output int lat);
    bit       issued;
    int       exp_lat;
    cpu_exp_t c;
    tick();
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    exp_lat   = model_slot(h_i, v_i, va_i) ? 3 : 2;
    c.is_write = we;
    c.data     = we ? wd : shadow[addr];
    if (we) shadow[addr] = wd;
    cpu_q.push_back(c);
    n_issued++;
    issued = 1'b0;
    lat    = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) tick();
      sample();
      if (cpu_ack) begin
        lat = i;
        if (!model_slot(h_i, v_i, va_i)) begin
          check("resp_port_idle_addr", mem_addr, 0);
          check("resp_port_idle_we", mem_we, 0);
          check("resp_port_idle_wdata", mem_wdata, 0);
        end
        break;
      end
      if (!issued && !model_slot(h_i, v_i, va_i)) begin
        issued = 1'b1;
        check("issue_addr", mem_addr, addr);
        check("issue_we", mem_we, we);
        check("issue_wdata", mem_wdata, wd);
      end
    end
    check("cpu_latency", lat, exp_lat);
  endtask

  task automatic cpu_release();
    tick();
    cpu_req = 1'b0;
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    win_vec_t tv [12];
    int       lat;
    int       k;
    int       base_issued;
    int       base_acked;
    bit       we;
    logic [15:0] addr;

    tv[0]  = '{-8,    0, 1'b1, 1'b1, 16'h4000};
    tv[1]  = '{0,     0, 1'b1, 1'b1, 16'h4001};
    tv[2]  = '{624,  17, 1'b1, 1'b1, 16'h40EF};
    tv[3]  = '{631,  17, 1'b1, 1'b0, 16'h0000};
    tv[4]  = '{632,  17, 1'b1, 1'b0, 16'h0000};
    tv[5]  = '{-16,   0, 1'b1, 1'b0, 16'h0000};
    tv[6]  = '{-8,  479, 1'b1, 1'b1, 16'h5270};
    tv[7]  = '{-8,  480, 1'b1, 1'b0, 16'h0000};
    tv[8]  = '{8,     8, 1'b0, 1'b0, 16'h0000};
    tv[9]  = '{4,     0, 1'b1, 1'b0, 16'h0000};
    tv[10] = '{312, 100, 1'b1, 1'b1, 16'h43E8};
    tv[11] = '{-160,  0, 1'b1, 1'b0, 16'h0000};

    for (int i = 0; i < 65536; i++) shadow[i] = init_byte(i);

    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    apply_timing();
    #1;
    check("reset_cpu_ack", cpu_ack, 0);
    check("reset_cpu_rdata", cpu_rdata, 0);
    check("reset_vid_valid", vid_valid, 0);
    check("reset_vid_data", vid_data, 0);
    check("reset_mem_we", mem_we, 0);
`ifdef VRAM_ARB_STATS_EN
    check("reset_stall_cnt", stall_cnt, 0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    sample();

    // Fetch-window vectors, CPU idle.
    for (int i = 0; i < 12; i++) begin
      h_i  = tv[i].h;
      v_i  = tv[i].v;
      va_i = tv[i].va;
      tick();
      sample();
      check("tbl_mem_addr", mem_addr, tv[i].exp_addr);
      check("tbl_mem_we", mem_we, 0);
      check("tbl_mem_wdata", mem_wdata, 0);
      h_i  = 0;
      v_i  = 500;
      va_i = 1'b0;
      tick();
      sample();
      check("tbl_vid_valid", vid_valid, tv[i].exp_slot);
    end

    // Write then back-to-back read during vblank.
    cpu_access(1'b1, 16'h1234, 8'hA5, lat);
    cpu_access(1'b0, 16'h1234, 8'h5A, lat);
    check("readback_A5", cpu_rdata, 8'hA5);
    cpu_release();

    // Request lands on a fetch slot: one stall cycle.
    tg_run = 1'b1;
    h_i    = -9;
    v_i    = 0;
    cpu_access(1'b0, 16'h1234, 8'h00, lat);
    check("stall_latency_3", lat, 3);
    check("stall_rdata", cpu_rdata, 8'hA5);
`ifdef VRAM_ARB_STATS_EN
    check("stall_cnt_one", stall_cnt, 1);
`endif
    cpu_release();
    tg_run = 1'b0;
    h_i    = 0;
    v_i    = 500;
    va_i   = 1'b0;
    repeat (2) begin
      tick();
      sample();
    end

    // Reset while the FSM is in RESP.
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h1234;
    sample();
    check("rst_issue_addr", mem_addr, 16'h1234);
    tick();
    #1;
    check("rst_pre_ack", cpu_ack, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ack", cpu_ack, 0);
    check("rst_async_rdata", cpu_rdata, 0);
    check("rst_async_vid_valid", vid_valid, 0);
    check("rst_async_vid_data", vid_data, 0);
`ifdef VRAM_ARB_STATS_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    cpu_req = 1'b0;
    vid_q.delete();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) rst_n = 1'b1;
      sample();
      check("no_ack_after_reset", cpu_ack, 0);
    end
    cpu_access(1'b0, 16'h1234, 8'h00, lat);
    check("post_reset_rdata", cpu_rdata, 8'hA5);
    cpu_release();

    // Continuous CPU traffic across one full active line.
    tg_run      = 1'b1;
    h_i         = 639;
    v_i         = 39;
    vid_pulses  = 0;
    count_vid   = 1'b1;
    base_issued = n_issued;
    base_acked  = n_acked;
    k           = 0;
    do begin
      we   = (k % 4 == 3);
      addr = we ? 16'h2000 + 16'(k) : 16'h2000 + 16'(k / 2);
      cpu_access(we, addr, 8'(k * 3 + 1), lat);
      k++;
    end while (v_i == 40 && k < 1000);
    cpu_release();
    count_vid = 1'b0;
    tg_run    = 1'b0;
    check("line_vid_pulses", vid_pulses, 80);
    check("line_acks_all", n_acked - base_acked, n_issued - base_issued);
    check("cpu_queue_drained", cpu_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter HSIZE, default 10, horizontal counter width.
REQ-002 SHALL have parameter VSIZE, default 10, vertical counter width.
REQ-003 SHALL have parameter AW, default 16, VRAM address width.
REQ-004 SHALL have parameter DW, default 8, VRAM data width.
REQ-005 SHALL have parameter VBASE, default 0, base address of the 80x60 tile map.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have ports hcntr, vcntr and vactive, inputs, HSIZE, VSIZE and 1 bit, from the timing generator; hcntr counts -160..640 two's complement.
REQ-009 SHALL have ports cpu_req, cpu_we, cpu_addr and cpu_wdata, inputs, 1, 1, AW and DW bits, the CPU request.
REQ-010 SHALL have ports cpu_ack and cpu_rdata, outputs, 1 and DW bits, the CPU completion.
REQ-011 SHALL have ports mem_addr, mem_we and mem_wdata, outputs, AW, 1 and DW bits, and port mem_rdata, input, DW bits, for single-port synchronous VRAM with 1-cycle read latency.
REQ-012 SHALL have ports vid_valid and vid_data, outputs, 1 and DW bits, the tile fetch result.

Function
REQ-013 SHALL assert vid_slot combinationally when vactive=1, vcntr<480, signed hcntr is in [-8,631] and hcntr[2:0]=0; there are 80 slots per line.
REQ-014 SHALL drive the VRAM from video in a vid_slot cycle, regardless of FSM state: mem_we=0 and mem_addr=VBASE+(vcntr>>3)*80+((hcntr+8)>>3), computed modulo 2^AW.
REQ-015 SHALL register vid_valid=1 and vid_data=mem_rdata in the cycle after each vid_slot, and vid_valid=0 otherwise.
REQ-016 SHALL implement an FSM with states IDLE and RESP.
REQ-017 SHALL, in IDLE with cpu_req=1 and vid_slot=0, drive mem_addr=cpu_addr, mem_we=cpu_we and mem_wdata=cpu_wdata for that cycle, then move to RESP.
REQ-018 SHALL, in IDLE with cpu_req=1 and vid_slot=1, stay in IDLE (stall cycle) with no CPU access issued.
REQ-019 SHALL, in RESP, assert cpu_ack=1 for exactly one cycle with cpu_rdata=mem_rdata (don't-care for writes), then return to IDLE.
REQ-020 SHALL give the CPU a minimum request-to-ack latency of 2 cycles, and no more than 3 cycles when a slot intervenes.
REQ-021 SHALL require the requester to hold cpu_req and its operands stable until ack; cpu_req high in the cycle after ack SHALL be treated as a new request, so back-to-back accesses complete every 2 cycles.
REQ-022 SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0 when neither video nor CPU owns the port.
REQ-023 SHALL never assert mem_we in a vid_slot cycle.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, cpu_ack=0, cpu_rdata=0, vid_valid=0 and vid_data=0, without waiting for a clock edge.
REQ-025 SHALL drop any in-flight CPU request on reset mid-access with no ack; the requester re-issues it after reset.

Configuration
REQ-026 SHALL, with VRAM_ARB_STATS_EN defined, add output stall_cnt of 16 bits, reset to 0, incrementing each stall cycle per REQ-018 and saturating at 0xFFFF.
REQ-027 SHALL, without VRAM_ARB_STATS_EN, have no stall_cnt port and no counter logic.

Structure
REQ-028 SHALL place the fetch-window constants (-8, 631, 480, 80 tiles per row, tile shift 3) and the FSM state encoding in shared package video_pkg.
REQ-029 SHALL put video address generation in sub-module vram_tile_addr, which is combinational and takes hcntr, vcntr and VBASE to produce the address; the arbiter stays a single module otherwise.

Verification
REQ-030 SHALL cover: vcntr=0, hcntr=-8 -> mem_addr=VBASE+0, mem_we=0; next cycle vid_valid=1 with vid_data = RAM[VBASE].
REQ-031 SHALL cover: vcntr=17, hcntr=631 -> no slot; at hcntr=624, mem_addr=VBASE+2*80+79=VBASE+239.
REQ-032 SHALL cover: CPU write 0xA5 to 0x1234 during vblank (vcntr=500) -> ack 2 cycles after req; a following read returns 0xA5 with ack at cycle 4.
REQ-033 SHALL cover: cpu_req asserted on a vid_slot cycle -> one stall; ack on cycle 3; stall_cnt=1 when STATS_EN is defined.
REQ-034 SHALL cover: rst_n low while state=RESP -> cpu_ack=0 immediately; after release no ack until a new request.
REQ-035 SHALL cover: continuous CPU reads over a full active line -> 80 vid_valid pulses, no mem_we in any slot, and all CPU acks in order.
